axi4_burst_master: RTL and testbench

Synthesizable, self-checking AXI4 burst master for the memory-mapped slave environment. Each accepted command drives an INCR write burst, a read burst, or a write-then-read-verify sequence on the full AXI4 AW/W/B/AR/R channels. It generates an incrementing data pattern and predicts the slave's BRESP/RRESP from address range and 4 KB boundary rules. It reports response errors, data mismatches and protocol errors. The block replaces the behavioural stimulus driver as a reusable, parametrised traffic source for the slave.

---
 rtl/axi4_burst_master_if.sv | 45 ++++
 rtl/axi4_burst_master.sv | 179 +++++++++++++++++
 tb/tb_axi4_burst_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_master_if.sv
// AXI4 AW/W/B/AR/R channel bundle used between the burst master and its slave.
// WSTRB, IDs and burst type are not carried; every burst is INCR with all lanes written.
interface axi4_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awlen, awsize, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arlen, arsize, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awaddr, awlen, awsize, awvalid, output awready,
    input wdata, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arlen, arsize, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// Self-checking AXI4 INCR burst master: write, read, or write-then-verify bursts with an
// incrementing data pattern, checking responses against a range / 4 KB boundary predictor.
module axi4_burst_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  axi4_burst_master_if.master   axi,
  output logic                  done,
  output logic                  resp_err,
  output logic                  proto_err,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic [1:0]            last_bresp,
  output logic [1:0]            last_rresp
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int PW       = ADDR_WIDTH + 12;

  logic [2:0]            state_reg;
  logic [1:0]            mode_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [2:0]            size_reg;
  logic [DATA_WIDTH-1:0] seed_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [7:0]            beat_reg;
  logic                  resp_err_reg;
  logic                  proto_err_reg;
  logic [CNT_WIDTH-1:0]  mismatch_reg;
  logic [1:0]            last_bresp_reg;
  logic [1:0]            last_rresp_reg;

  // Response predictor, evaluated on the latched command so it is stable for the whole burst.
  logic [PW-1:0]         beats_w;
  logic [PW-1:0]         bytes_w;
  logic [PW-1:0]         page_off_w;
  logic [PW-1:0]         word_w;
  logic                  exp_err;
  logic [1:0]            exp_resp;
  logic [DATA_WIDTH-1:0] rexp_w;
  logic                  reject_w;
  logic                  last_beat_w;

  always_comb begin
    beats_w    = PW'(len_reg) + PW'(1);
    bytes_w    = beats_w << size_reg;
    page_off_w = PW'(addr_reg) & PW'(4095);
    word_w     = PW'(addr_reg) >> 2;
    exp_err    = ((page_off_w + bytes_w) > PW'(4096)) ||
                 ((word_w + beats_w) > PW'(MEMORY_DEPTH));
    exp_resp   = exp_err ? 2'b10 : 2'b00;
    rexp_w     = seed_reg + DATA_WIDTH'(beat_reg);
    reject_w   = (cmd_mode == 2'b11) || (int'(cmd_size) > MAX_SIZE);
    last_beat_w = (beat_reg == len_reg);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= S_IDLE;
      mode_reg       <= 2'b00;
      addr_reg       <= '0;
      len_reg        <= 8'd0;
      size_reg       <= 3'd0;
      seed_reg       <= '0;
      wdata_reg      <= '0;
      beat_reg       <= 8'd0;
      resp_err_reg   <= 1'b0;
      proto_err_reg  <= 1'b0;
      mismatch_reg   <= '0;
      last_bresp_reg <= 2'b00;
      last_rresp_reg <= 2'b00;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            mode_reg      <= cmd_mode;
            addr_reg      <= cmd_addr;
            len_reg       <= cmd_len;
            size_reg      <= cmd_size;
            seed_reg      <= cmd_seed;
            wdata_reg     <= cmd_seed;
            beat_reg      <= 8'd0;
            resp_err_reg  <= 1'b0;
            proto_err_reg <= reject_w;
            mismatch_reg  <= '0;
            if (reject_w)                state_reg <= S_DONE;
            else if (cmd_mode == 2'b01)  state_reg <= S_AR;
            else                         state_reg <= S_AW;
          end
        end
        S_AW: if (axi.awready) state_reg <= S_W;
        S_W: begin
          if (axi.wready) begin
            if (last_beat_w) begin
              beat_reg  <= 8'd0;
              state_reg <= S_B;
            end else begin
              beat_reg  <= beat_reg + 8'd1;
              wdata_reg <= wdata_reg + DATA_WIDTH'(1);
            end
          end
        end
        S_B: begin
          if (axi.bvalid) begin
            last_bresp_reg <= axi.bresp;
            if (axi.bresp != exp_resp) resp_err_reg <= 1'b1;
            state_reg <= (mode_reg == 2'b10) ? S_AR : S_DONE;
          end
        end
        S_AR: begin
          if (axi.arready) begin
            beat_reg  <= 8'd0;
            state_reg <= S_R;
          end
        end
        S_R: begin
          if (axi.rvalid) begin
            last_rresp_reg <= axi.rresp;
            if (axi.rresp != exp_resp) resp_err_reg <= 1'b1;
            // Data is only meaningful when this command wrote it and the slave accepted it.
            if ((mode_reg == 2'b10) && !exp_err && (axi.rdata != rexp_w) &&
                (mismatch_reg != {CNT_WIDTH{1'b1}}))
              mismatch_reg <= mismatch_reg + CNT_WIDTH'(1);
            if (last_beat_w) begin
              if (!axi.rlast) proto_err_reg <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              if (axi.rlast) proto_err_reg <= 1'b1;
              beat_reg <= beat_reg + 8'd1;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state, so VALID never depends on READY.
  assign cmd_ready   = (state_reg == S_IDLE);
  assign axi.awaddr  = addr_reg;
  assign axi.awlen   = len_reg;
  assign axi.awsize  = size_reg;
  assign axi.awvalid = (state_reg == S_AW);
  assign axi.wdata   = wdata_reg;
  assign axi.wvalid  = (state_reg == S_W);
  assign axi.wlast   = (state_reg == S_W) && last_beat_w;
  assign axi.bready  = (state_reg == S_B);
  assign axi.araddr  = addr_reg;
  assign axi.arlen   = len_reg;
  assign axi.arsize  = size_reg;
  assign axi.arvalid = (state_reg == S_AR);
  assign axi.rready  = (state_reg == S_R);

  assign done         = (state_reg == S_DONE);
  assign resp_err     = resp_err_reg;
  assign proto_err    = proto_err_reg;
  assign mismatch_cnt = mismatch_reg;
  assign last_bresp   = last_bresp_reg;
  assign last_rresp   = last_rresp_reg;
endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench plays the AXI slave cycle by cycle,
// driving at the falling edge and sampling there, away from the rising edge.
module tb_axi4_burst_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = 8'd0;
  logic [2:0]    cmd_size = 3'd0;
  logic [DW-1:0] cmd_seed = '0;
  logic          done;
  logic          resp_err;
  logic          proto_err;
  logic [CW-1:0] mismatch_cnt;
  logic [1:0]    last_bresp;
  logic [1:0]    last_rresp;

  int n_checks = 0;
  int n_pass = 0;

  always #5 aclk = ~aclk;

  axi4_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(1024), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_seed(cmd_seed),
    .axi(bus.master),
    .done(done), .resp_err(resp_err), .proto_err(proto_err), .mismatch_cnt(mismatch_cnt),
    .last_bresp(last_bresp), .last_rresp(last_rresp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // All tasks below enter and leave at a falling edge.
  task automatic issue(input logic [1:0] m, input logic [15:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [31:0] sd);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    check("cmd_ready", cmd_ready, 1);
    cmd_mode = m; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_seed = sd; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic slave_aw(input int delay, input logic [15:0] ea, input logic [7:0] el);
    int n = 0;
    while (!bus.awvalid && n < 20) begin @(negedge aclk); n++; end
    check("awvalid", bus.awvalid, 1);
    for (int k = 0; k < delay; k++) begin
      check("aw_hold_valid", bus.awvalid, 1);
      check("aw_hold_addr", bus.awaddr, ea);
      @(negedge aclk);
    end
    check("awaddr", bus.awaddr, ea);
    check("awlen", bus.awlen, el);
    bus.awready = 1'b1;
    @(negedge aclk);
    bus.awready = 1'b0;
  endtask

  task automatic slave_w(input int len, input logic [31:0] seed, input bit toggle);
    int i = 0;
    int n = 0;
    int lasts = 0;
    while (i <= len && n < 200) begin
      bus.wready = toggle ? ((n % 2) == 1) : 1'b1;
      if (bus.wready) begin
        check("wvalid", bus.wvalid, 1);
        check("wdata", bus.wdata, seed + 32'(i));
        check("wlast", bus.wlast, (i == len));
        if (bus.wlast) lasts++;
        i++;
      end
      @(negedge aclk);
      n++;
    end
    bus.wready = 1'b0;
    check("w_beats", 64'(i), 64'(len + 1));
    check("w_last_count", 64'(lasts), 1);
  endtask

  task automatic slave_b(input logic [1:0] resp);
    int n = 0;
    while (!bus.bready && n < 20) begin @(negedge aclk); n++; end
    check("bready", bus.bready, 1);
    bus.bvalid = 1'b1; bus.bresp = resp;
    @(negedge aclk);
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
  endtask

  task automatic slave_ar(input logic [15:0] ea, input logic [7:0] el);
    int n = 0;
    while (!bus.arvalid && n < 20) begin @(negedge aclk); n++; end
    check("arvalid", bus.arvalid, 1);
    check("araddr", bus.araddr, ea);
    check("arlen", bus.arlen, el);
    bus.arready = 1'b1;
    @(negedge aclk);
    bus.arready = 1'b0;
  endtask

  task automatic slave_r(input int len, input logic [1:0] resp, input logic [31:0] seed,
                         input int c1, input int c2, input int early);
    int n = 0;
    while (!bus.rready && n < 20) begin @(negedge aclk); n++; end
    check("rready", bus.rready, 1);
    for (int i = 0; i <= len; i++) begin
      bus.rvalid = 1'b1;
      bus.rresp  = resp;
      bus.rdata  = seed + 32'(i);
      if (i == c1 || i == c2) bus.rdata = bus.rdata ^ 32'h0000_0100;
      bus.rlast  = (i == len) || (i == early);
      @(negedge aclk);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin @(negedge aclk); n++; end
    check("done_pulse", done, 1);
    @(negedge aclk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
    bus.rdata = '0;

    // Reset values
    repeat (2) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch_cnt, 0);
    check("rst_awaddr", bus.awaddr, 0);
    check("rst_wdata", bus.wdata, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Mode 10, in-range, correct slave
    issue(2'b10, 16'h0040, 8'd3, 3'd2, 32'hA000_0000);
    slave_aw(0, 16'h0040, 8'd3);
    slave_w(3, 32'hA000_0000, 1'b0);
    slave_b(2'b00);
    slave_ar(16'h0040, 8'd3);
    slave_r(3, 2'b00, 32'hA000_0000, -1, -1, -1);
    wait_done();
    check("t1_resp_err", resp_err, 0);
    check("t1_proto_err", proto_err, 0);
    check("t1_mismatch", mismatch_cnt, 0);
    check("t1_last_rresp", last_rresp, 2'b00);

    // Mode 00 crossing 4 KB: SLVERR is the predicted answer
    issue(2'b00, 16'h0FF8, 8'd3, 3'd2, 32'h0000_0010);
    slave_aw(0, 16'h0FF8, 8'd3);
    slave_w(3, 32'h0000_0010, 1'b0);
    slave_b(2'b10);
    wait_done();
    check("t2a_resp_err", resp_err, 0);
    check("t2a_last_bresp", last_bresp, 2'b10);
    issue(2'b00, 16'h0FF8, 8'd3, 3'd2, 32'h0000_0010);
    slave_aw(0, 16'h0FF8, 8'd3);
    slave_w(3, 32'h0000_0010, 1'b0);
    slave_b(2'b00);
    wait_done();
    check("t2b_resp_err", resp_err, 1);
    check("t2b_last_bresp", last_bresp, 2'b00);

    // Stray BVALID in IDLE is ignored
    bus.bvalid = 1'b1; bus.bresp = 2'b11;
    @(negedge aclk);
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    check("stray_b_ready", cmd_ready, 1);
    check("stray_b_bresp", last_bresp, 2'b00);

    // Mode 01 beyond memory depth, SLVERR on all beats, data never compared
    issue(2'b01, 16'h0FF0, 8'd7, 3'd2, 32'h0000_0000);
    slave_ar(16'h0FF0, 8'd7);
    slave_r(7, 2'b10, 32'hDEAD_0000, 0, 3, -1);
    wait_done();
    check("t3_resp_err", resp_err, 0);
    check("t3_mismatch", mismatch_cnt, 0);
    check("t3_last_rresp", last_rresp, 2'b10);
    check("t3_proto_err", proto_err, 0);

    // Mode 10 len 15 with AW stall, toggling WREADY, two corrupted read beats
    issue(2'b10, 16'h0100, 8'd15, 3'd2, 32'h1234_5678);
    slave_aw(5, 16'h0100, 8'd15);
    slave_w(15, 32'h1234_5678, 1'b1);
    slave_b(2'b00);
    slave_ar(16'h0100, 8'd15);
    slave_r(15, 2'b00, 32'h1234_5678, 2, 9, -1);
    wait_done();
    check("t4_mismatch", mismatch_cnt, 2);
    check("t4_proto_err", proto_err, 0);
    check("t4_resp_err", resp_err, 0);

    // Same burst with an early RLAST on beat 14
    issue(2'b10, 16'h0100, 8'd15, 3'd2, 32'h1234_5678);
    slave_aw(0, 16'h0100, 8'd15);
    slave_w(15, 32'h1234_5678, 1'b0);
    slave_b(2'b00);
    slave_ar(16'h0100, 8'd15);
    slave_r(15, 2'b00, 32'h1234_5678, 2, 9, 14);
    wait_done();
    check("t5_mismatch", mismatch_cnt, 2);
    check("t5_proto_err", proto_err, 1);

    // Rejections: reserved mode, then oversize beat
    issue(2'b11, 16'h0000, 8'd0, 3'd2, 32'h0);
    check("rej_mode_awvalid", bus.awvalid, 0);
    check("rej_mode_arvalid", bus.arvalid, 0);
    wait_done();
    check("rej_mode_proto", proto_err, 1);
    issue(2'b00, 16'h0000, 8'd0, 3'd3, 32'h0);
    check("rej_size_awvalid", bus.awvalid, 0);
    check("rej_size_arvalid", bus.arvalid, 0);
    wait_done();
    check("rej_size_proto", proto_err, 1);

    // Reset in the middle of the W phase
    issue(2'b00, 16'h0020, 8'd3, 3'd2, 32'h0000_0055);
    slave_aw(0, 16'h0020, 8'd3);
    bus.wready = 1'b1;
    @(negedge aclk);
    check("mid_w_wdata", bus.wdata, 32'h0000_0056);
    aresetn = 1'b0;
    #1;
    bus.wready = 1'b0;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_wvalid", bus.wvalid, 0);
    check("mid_rst_wdata", bus.wdata, 0);
    check("mid_rst_awaddr", bus.awaddr, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_proto", proto_err, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Recovery: single-beat write completes cleanly
    issue(2'b00, 16'h0200, 8'd0, 3'd2, 32'hCAFE_0000);
    slave_aw(0, 16'h0200, 8'd0);
    slave_w(0, 32'hCAFE_0000, 1'b0);
    slave_b(2'b00);
    wait_done();
    check("recov_resp_err", resp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
